// File: rtl/reg8_ctrl_pkg.sv
// rtl/reg8_ctrl_pkg.sv - shared mode and state encodings for the reg8 access controller
package reg8_ctrl_pkg;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_INC  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_ISSUE  = 2'd2
  } state_t;

endpackage

// File: rtl/reg8_access_ctrl_rr_arb2.sv
// rtl/reg8_access_ctrl_rr_arb2.sv - two-input round-robin arbiter with registered last-grant pointer
module rr_arb2 #(
  parameter int FIRST_CLIENT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       done_id,
  output logic       gnt_id,
  output logic       valid
);

  logic last_id;

  // Pretend the other client was served last so FIRST_CLIENT wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_id <= (FIRST_CLIENT == 0) ? 1'b1 : 1'b0;
    else if (update)
      last_id <= done_id;
  end

  always_comb begin
    valid  = |req;
    gnt_id = (req == 2'b11) ? ~last_id : req[1];
  end

endmodule

// File: rtl/reg8_access_ctrl.sv
// rtl/reg8_access_ctrl.sv - arbitrates two clients onto the load/increment register, sequencing mode switches
module reg8_access_ctrl
  import reg8_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int FIRST_CLIENT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic [WIDTH-1:0] reg_in,
  output logic             reg_ld_inc,
  output logic             reg_choose,
  output logic             busy
);

  state_t           state, state_nx;
  logic             mirror, mirror_nx;
  logic             lat_id, lat_id_nx;
  logic             lat_op, lat_op_nx;
  logic [WIDTH-1:0] lat_data, lat_data_nx;

  logic             gnt_id, gnt_valid, arb_update;
  logic             sel_op;
  logic [WIDTH-1:0] sel_data;
  logic             fire, fire_id, fire_op;
  logic [WIDTH-1:0] fire_data;

  logic             ack0_nx, ack1_nx, ld_nx, choose_nx, busy_nx;
  logic [WIDTH-1:0] in_nx;

  rr_arb2 #(.FIRST_CLIENT(FIRST_CLIENT)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .update  (arb_update),
    .done_id (lat_id),
    .gnt_id  (gnt_id),
    .valid   (gnt_valid)
  );

  always_comb begin
    state_nx    = state;
    mirror_nx   = mirror;
    lat_id_nx   = lat_id;
    lat_op_nx   = lat_op;
    lat_data_nx = lat_data;
    arb_update  = 1'b0;
    fire        = 1'b0;
    fire_id     = lat_id;
    fire_op     = lat_op;
    fire_data   = lat_data;
    choose_nx   = mirror;
    sel_op      = gnt_id ? op1 : op0;
    sel_data    = gnt_id ? data1 : data0;

    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          lat_id_nx   = gnt_id;
          lat_op_nx   = sel_op;
          lat_data_nx = sel_data;
          if (sel_op == mirror) begin
            state_nx  = ST_ISSUE;
            fire      = 1'b1;
            fire_id   = gnt_id;
            fire_op   = sel_op;
            fire_data = sel_data;
          end else begin
            state_nx  = ST_SWITCH;
            choose_nx = sel_op;
          end
        end
      end
      // The register adopts the new mode at the end of this cycle, so the mirror moves with it.
      ST_SWITCH: begin
        state_nx  = ST_ISSUE;
        mirror_nx = lat_op;
        choose_nx = lat_op;
        fire      = 1'b1;
      end
      ST_ISSUE: begin
        state_nx   = ST_IDLE;
        arb_update = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase

    ld_nx   = fire;
    ack0_nx = fire & ~fire_id;
    ack1_nx = fire & fire_id;
    in_nx   = (fire && fire_op == MODE_LOAD) ? fire_data : '0;
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mirror     <= MODE_LOAD;
      lat_id     <= 1'b0;
      lat_op     <= MODE_LOAD;
      lat_data   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      reg_in     <= '0;
      reg_ld_inc <= 1'b0;
      reg_choose <= MODE_LOAD;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      mirror     <= mirror_nx;
      lat_id     <= lat_id_nx;
      lat_op     <= lat_op_nx;
      lat_data   <= lat_data_nx;
      ack0       <= ack0_nx;
      ack1       <= ack1_nx;
      reg_in     <= in_nx;
      reg_ld_inc <= ld_nx;
      reg_choose <= choose_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_reg8_access_ctrl.sv
// tb/tb_reg8_access_ctrl.sv - scoreboard bench for reg8_access_ctrl with a behavioural register model
module tb_reg8_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, reg_ld_inc, reg_choose, busy;
  logic [7:0] reg_in;

  typedef struct {
    int         client;
    logic [7:0] data;
    logic [7:0] regval;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  int         cnt0 = 0;
  int         cnt1 = 0;
  logic       reg_pending = 1'b0;
  logic [7:0] exp_reg = 8'h00;
  logic [7:0] model_q;
  logic       model_mode;

  reg8_access_ctrl #(.WIDTH(8), .FIRST_CLIENT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .op0        (op0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .op1        (op1),
    .data1      (data1),
    .ack1       (ack1),
    .reg_in     (reg_in),
    .reg_ld_inc (reg_ld_inc),
    .reg_choose (reg_choose),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The 8-bit register: mode follows choose every edge, ld_inc loads or increments using the current mode.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q    <= 8'h00;
      model_mode <= 1'b0;
    end else begin
      if (reg_ld_inc) model_q <= model_mode ? model_q + 8'd1 : reg_in;
      model_mode <= reg_choose;
    end
  end

  task automatic push(input int client, input logic [7:0] data, input logic [7:0] regval, input int at);
    exp_t e;
    e.client = client;
    e.data   = data;
    e.regval = regval;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  // Scoreboard: step cycles, pop an expectation on every ack, release requests as clients would.
  task automatic service(input int budget);
    int   n = 0;
    exp_t e;
    while ((cnt0 > 0 || cnt1 > 0 || sb.size() > 0 || reg_pending) && n < budget) begin
      @(negedge clk);
      n++;
      if (reg_pending) begin
        checks++;
        if (model_q !== exp_reg) begin
          fails++;
          $display("FAIL reg_value: got %h expected %h", model_q, exp_reg);
        end
        reg_pending = 1'b0;
      end
      if (reg_ld_inc) begin
        checks++;
        if (reg_choose !== model_mode) begin
          fails++;
          $display("FAIL ld_inc_mode: choose %b register mode %b", reg_choose, model_mode);
        end
      end
      checks++;
      if (reg_ld_inc !== (ack0 | ack1) || (ack0 & ack1)) begin
        fails++;
        $display("FAIL ack_ld_pairing: ld_inc %b ack0 %b ack1 %b", reg_ld_inc, ack0, ack1);
      end
      if (ack0 || ack1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack: ack0 %b ack1 %b with nothing pending", ack0, ack1);
        end else begin
          e = sb.pop_front();
          checks++;
          if ((ack1 ? 1 : 0) != e.client) begin
            fails++;
            $display("FAIL grant_order: client %0d expected %0d", ack1 ? 1 : 0, e.client);
          end
          checks++;
          if (reg_in !== e.data) begin
            fails++;
            $display("FAIL reg_in: got %h expected %h", reg_in, e.data);
          end
          checks++;
          if (cyc != e.cyc) begin
            fails++;
            $display("FAIL ack_latency: ack in cycle %0d expected %0d", cyc, e.cyc);
          end
          exp_reg     = e.regval;
          reg_pending = 1'b1;
        end
        if (ack0 && cnt0 > 0) begin
          cnt0--;
          if (cnt0 == 0) req0 = 1'b0;
        end
        if (ack1 && cnt1 > 0) begin
          cnt1--;
          if (cnt1 == 0) req1 = 1'b0;
        end
      end
    end
    if (cnt0 > 0 || cnt1 > 0 || sb.size() > 0 || reg_pending) begin
      checks++;
      fails++;
      $display("FAIL timeout: %0d acks still outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
      cnt0 = 0;
      cnt1 = 0;
      req0 = 1'b0;
      req1 = 1'b0;
      reg_pending = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, reg_ld_inc, reg_choose, busy, reg_in} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected all zero", {ack0, ack1, reg_ld_inc, reg_choose, busy, reg_in});
    end
    rst = 1'b0;
  endtask

  task automatic test_load_same_mode();
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h5A; cnt0 = 1;
    push(0, 8'h5A, 8'h5A, cyc + 1);
    service(10);
  endtask

  task automatic test_switch_inc();
    int c0;
    req1 = 1'b1; op1 = 1'b1; data1 = 8'h77; cnt1 = 1;
    c0 = cyc;
    push(1, 8'h00, 8'h5B, c0 + 2);
    @(negedge clk);
    checks++;
    if (reg_choose !== 1'b1 || reg_ld_inc !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL switch_cycle: choose %b ld_inc %b busy %b expected 1 0 1", reg_choose, reg_ld_inc, busy);
    end
    service(10);
  endtask

  task automatic test_round_robin();
    int c0;
    req1 = 1'b1; op1 = 1'b0; data1 = 8'hFE; cnt1 = 1;
    push(1, 8'hFE, 8'hFE, cyc + 2);
    service(10);
    req0 = 1'b1; op0 = 1'b1; cnt0 = 2;
    req1 = 1'b1; op1 = 1'b1; cnt1 = 1;
    c0 = cyc;
    push(0, 8'h00, 8'hFF, c0 + 2);
    push(1, 8'h00, 8'h00, c0 + 4);
    push(0, 8'h00, 8'h01, c0 + 6);
    service(20);
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; op0 = i[0]; data0 = 8'h10; cnt0 = 1;
      push(0, i[0] ? 8'h00 : 8'h10, i[0] ? 8'h11 : 8'h10, cyc + 2);
      service(10);
    end
  endtask

  task automatic test_reset_mid_switch();
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h33;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || reg_choose !== 1'b0) begin
      fails++;
      $display("FAIL mid_switch_state: busy %b choose %b expected 1 0", busy, reg_choose);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, reg_ld_inc, reg_choose, busy, reg_in} !== 13'd0) begin
      fails++;
      $display("FAIL async_reset: got %b expected all zero", {ack0, ack1, reg_ld_inc, reg_choose, busy, reg_in});
    end
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL lost_ack: ack0 %b ack1 %b busy %b expected 0 0 0", ack0, ack1, busy);
      end
    end
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h33; cnt0 = 1;
    push(0, 8'h33, 8'h33, cyc + 1);
    service(10);
  endtask

  task automatic test_first_client();
    int c0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; op0 = 1'b0; data0 = 8'h11; cnt0 = 1;
    req1 = 1'b1; op1 = 1'b0; data1 = 8'h22; cnt1 = 1;
    c0 = cyc;
    push(0, 8'h11, 8'h11, c0 + 1);
    push(1, 8'h22, 8'h22, c0 + 3);
    service(20);
  endtask

  initial begin
    test_reset();
    test_load_same_mode();
    test_switch_inc();
    test_round_robin();
    test_alternate();
    test_reset_mid_switch();
    test_first_client();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
